// File: rtl/alu_result_stage.sv
// Registered output stage of the ALU: captures result, op code and Z/N/C flags,
// and hands them downstream through a 2-entry skid buffer with a registered in_ready.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OPW-1:0]   out_op,
    output logic             out_z,
    output logic             out_n,
    output logic             out_c,
    output logic [CNTW-1:0]  done_count
);

    localparam logic [OPW-1:0]   OP_SLL  = {OPW{1'b0}};
    localparam logic [OPW-1:0]   OP_SRL  = {{(OPW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_V  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [CNTW-1:0]  CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    // Encoding is {out_valid, skid_full}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [OPW-1:0]   op;
        logic             z;
        logic             n;
        logic             c;
    } entry_t;

    localparam entry_t ENTRY_CLR = '{result: {WIDTH{1'b0}}, op: {OPW{1'b0}},
                                     z: 1'b0, n: 1'b0, c: 1'b0};

    // Last bit shifted out; the full shift amount is examined, out-of-range gives 0.
    function automatic logic shift_carry(input logic [OPW-1:0]   op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] shifted;
        logic             c;
        shifted = ZERO_V;
        c       = 1'b0;
        if ((b == ZERO_V) || (b > WIDTH_V)) begin
            c = 1'b0;
        end else if (op == OP_SLL) begin
            shifted = a >> (WIDTH_V - b);
            c       = shifted[0];
        end else if (op == OP_SRL) begin
            shifted = a >> (b - ONE_V);
            c       = shifted[0];
        end else begin
            c = 1'b0;
        end
        return c;
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    entry_t          main_r;
    entry_t          skid_r;
    entry_t          in_entry_s;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [CNTW-1:0] done_count_r;
    logic            accept_s;
    logic            transfer_s;
    logic            load_main_in_s;
    logic            load_main_skid_s;
    logic            load_skid_s;

    assign accept_s   = in_valid & in_ready_r;
    assign transfer_s = out_valid_r & out_ready;

    // Build the entry to capture, flags computed from the upstream operands.
    always_comb begin
        in_entry_s        = ENTRY_CLR;
        in_entry_s.result = in_result;
        in_entry_s.op     = in_op;
        in_entry_s.z      = (in_result == ZERO_V);
        in_entry_s.n      = in_result[WIDTH-1];
        in_entry_s.c      = shift_carry(in_op, in_a, in_b);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = ST_EMPTY;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s = ST_ONE;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && !transfer_s) begin
                    state_next_s = ST_FULL;
                end else if (!accept_s && transfer_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (transfer_s) begin
                    state_next_s = ST_ONE;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // Datapath steering; the skid entry only ever refills main, keeping FIFO order.
    always_comb begin
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                load_main_in_s = accept_s;
            end
            ST_ONE: begin
                if (accept_s && transfer_s) begin
                    load_main_in_s = 1'b1;
                end else if (accept_s) begin
                    load_skid_s = 1'b1;
                end else begin
                    load_main_in_s = 1'b0;
                end
            end
            ST_FULL: begin
                load_main_skid_s = transfer_s;
            end
            default: begin
                load_main_in_s = 1'b0;
            end
        endcase
    end

    // Main and skid entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r <= ENTRY_CLR;
            skid_r <= ENTRY_CLR;
        end else begin
            if (load_main_in_s) begin
                main_r <= in_entry_s;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= in_entry_s;
            end
        end
    end

    // Handshake outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            out_valid_r <= state_next_s[1];
            in_ready_r  <= ~state_next_s[0];
        end
    end

    // Completed-transfer counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_count_r <= {CNTW{1'b0}};
        end else if (transfer_s) begin
            done_count_r <= done_count_r + CNT_ONE;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = main_r.result;
    assign out_op     = main_r.op;
    assign out_z      = main_r.z;
    assign out_n      = main_r.n;
    assign out_c      = main_r.c;
    assign done_count = done_count_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage: reset, flags, backpressure,
// streaming, counter wrap and mid-operation reset.
module tb_alu_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_op;
    logic        out_z;
    logic        out_n;
    logic        out_c;
    logic [15:0] done_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_stage #(.WIDTH(32), .OPW(4), .CNTW(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op),
        .out_z(out_z), .out_n(out_n), .out_c(out_c),
        .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag vectors: op, a, b, result, expected {z,n,c}.
    localparam int NV = 9;
    localparam logic [3:0]  VOP[NV] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2};
    localparam logic [31:0] VA[NV]  = '{32'h8000_0001, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003, 32'h8000_0000,
                                        32'hFFFF_FFFF};
    localparam logic [31:0] VB[NV]  = '{32'd1, 32'd1, 32'd32, 32'd33, 32'h8000_0001, 32'd0,
                                        32'd1, 32'd32, 32'd1};
    localparam logic [31:0] VR[NV]  = '{32'h0000_0002, 32'h8000_0000, 32'h0, 32'h0, 32'h0,
                                        32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0};
    localparam logic [2:0]  VF[NV]  = '{3'b001, 3'b010, 3'b101, 3'b100, 3'b100, 3'b010,
                                        3'b001, 3'b101, 3'b100};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid  = v;
        in_result = r;
        in_op     = op;
        in_a      = a;
        in_b      = b;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        drive(1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        out_ready = 1'b0;
        drive(1'b1, 32'h1234_5678, 4'h3, 32'h1, 32'h1);
        tick;
        drive(1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_handshake: got valid/ready=%b required 01", {out_valid, in_ready});
        end
        n_checks++;
        if (done_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_count: got %h required 0000", done_count);
        end
        n_checks++;
        if ({out_result, out_op, out_z, out_n, out_c} !== 39'h0) begin
            n_fail++;
            $display("FAIL reset_fields: got result=%h op=%h znc=%b required all zero",
                     out_result, out_op, {out_z, out_n, out_c});
        end
    endtask

    task automatic test_single_sll;
        apply_reset;
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 4'd0, 32'h1, 32'd4);
        tick;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h10) begin
            n_fail++;
            $display("FAIL single_sll_data: got valid=%b result=%h required 1 00000010", out_valid, out_result);
        end
        n_checks++;
        if ({out_z, out_n, out_c} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_sll_flags: got znc=%b required 000", {out_z, out_n, out_c});
        end
        out_ready = 1'b1;
        tick;
        n_checks++;
        if (done_count !== 16'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_sll_count: got count=%0d valid=%b required 1 0", done_count, out_valid);
        end
    endtask

    task automatic test_flags;
        apply_reset;
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, VR[i], VOP[i], VA[i], VB[i]);
            tick;
            in_valid = 1'b0;
            n_checks++;
            if ({out_z, out_n, out_c} !== VF[i] || out_result !== VR[i] || out_op !== VOP[i]) begin
                n_fail++;
                $display("FAIL flags_vec%0d: got znc=%b result=%h op=%h required znc=%b result=%h op=%h",
                         i, {out_z, out_n, out_c}, out_result, out_op, VF[i], VR[i], VOP[i]);
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] got[$];
        logic        acc;
        apply_reset;
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 4'd2, 32'h0, 32'h0);
        tick;
        drive(1'b1, 32'hB, 4'd2, 32'h0, 32'h0);
        tick;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full_ready: got in_ready=%b required 0", in_ready);
        end
        drive(1'b1, 32'hC, 4'd2, 32'h0, 32'h0);
        tick;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'hA) begin
            n_fail++;
            $display("FAIL bp_stall_hold: got ready=%b valid=%b result=%h required 0 1 0000000a",
                     in_ready, out_valid, out_result);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) got.push_back(out_result);
            acc = in_valid & in_ready;
            tick;
            if (acc) in_valid = 1'b0;
        end
        n_checks++;
        if (got.size() != 3 || got[0] !== 32'hA || got[1] !== 32'hB || got[2] !== 32'hC) begin
            n_fail++;
            $display("FAIL bp_order: got %0d outputs first=%h,%h,%h required 3 outputs a,b,c",
                     got.size(), (got.size() > 0) ? got[0] : 32'hX,
                     (got.size() > 1) ? got[1] : 32'hX, (got.size() > 2) ? got[2] : 32'hX);
        end
        n_checks++;
        if (done_count !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d required 3", done_count);
        end
    endtask

    task automatic test_streaming;
        int errs;
        apply_reset;
        out_ready = 1'b1;
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'(i) + 32'h100, 4'd2, 32'h0, 32'h0);
            tick;
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== 32'(i) + 32'h100) begin
                n_fail++;
                errs++;
                if (errs < 5)
                    $display("FAIL stream_cycle%0d: got ready=%b valid=%b result=%h required 1 1 %h",
                             i, in_ready, out_valid, out_result, 32'(i) + 32'h100);
            end
        end
        in_valid = 1'b0;
        tick;
        n_checks++;
        if (done_count !== 16'd100 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_count: got count=%0d valid=%b required 100 0", done_count, out_valid);
        end
    endtask

    task automatic test_counter_wrap;
        apply_reset;
        out_ready = 1'b1;
        drive(1'b1, 32'h5, 4'd2, 32'h0, 32'h0);
        for (int i = 0; i < 65536; i++) tick;
        n_checks++;
        if (done_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: got %h required ffff", done_count);
        end
        in_valid = 1'b0;
        tick;
        n_checks++;
        if (done_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_rollover: got %h required 0000", done_count);
        end
    endtask

    task automatic test_mid_reset;
        apply_reset;
        out_ready = 1'b1;
        drive(1'b1, 32'h55, 4'd2, 32'h0, 32'h0);
        tick;
        in_valid = 1'b0;
        tick;
        out_ready = 1'b0;
        drive(1'b1, 32'h66, 4'd2, 32'h0, 32'h0);
        tick;
        drive(1'b1, 32'h77, 4'd2, 32'h0, 32'h0);
        tick;
        n_checks++;
        if (in_ready !== 1'b0 || done_count !== 16'd1) begin
            n_fail++;
            $display("FAIL midrst_full: got ready=%b count=%0d required 0 1", in_ready, done_count);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || done_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: got valid=%b ready=%b count=%0d required 0 1 0",
                     out_valid, in_ready, done_count);
        end
        drive(1'b1, 32'h88, 4'd2, 32'h0, 32'h0);
        tick;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h88) begin
            n_fail++;
            $display("FAIL midrst_fresh: got valid=%b result=%h required 1 00000088", out_valid, out_result);
        end
        tick;
        n_checks++;
        if (out_valid !== 1'b0 || done_count !== 16'd1) begin
            n_fail++;
            $display("FAIL midrst_nostale: got valid=%b result=%h count=%0d required 0 - 1",
                     out_valid, out_result, done_count);
        end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        tick;
        tick;
        rst = 1'b0;
        test_reset;
        test_single_sll;
        test_flags;
        test_backpressure;
        test_streaming;
        test_counter_wrap;
        test_mid_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
